sec32_check_encoder: RTL and testbench

// Transmit-side partner of the 32-bit single-error-correcting checker: computes the 8 check bits
// for a 32-bit data word so that the checker sees an all-zero syndrome. Accepts words on a

---
 rtl/sec32_check_encoder_if.sv | 21 ++
 rtl/sec32_check_encoder.sv | 114 +++++++++++
 tb/tb_sec32_check_encoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sec32_check_encoder_if.sv
// rtl/sec32_check_encoder_if.sv - valid/ready data and codeword stream bundle for the SEC-32 encoder
`timescale 1ns/1ps
interface sec32_check_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_chk;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_chk
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_chk
    );
endinterface

// File: rtl/sec32_check_encoder.sv
// rtl/sec32_check_encoder.sv - SEC-32 check-bit encoder with 2-entry codeword queue and fault injection
`timescale 1ns/1ps
module sec32_check_encoder #(
    parameter int CNT_W  = 16,
    parameter bit INJ_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    sec32_check_encoder_if.slave s,
    input  logic             inj_arm,
    input  logic [5:0]       inj_pos,
    output logic             inj_busy,
    output logic [CNT_W-1:0] sent_cnt
);

    localparam logic [7:0][31:0] MASK = {
        32'h8888F0F0, 32'h44440F0F, 32'h2222FF00, 32'h111100FF,
        32'hF0F08888, 32'h0F0F4444, 32'hFF002222, 32'h00FF1111
    };

    logic [1:0]  count;
    logic [31:0] e0_data, e1_data;
    logic [7:0]  e0_chk,  e1_chk;
    logic        arm_q;
    logic [5:0]  pos_q;

    logic        push, pop, eff_arm;
    logic [5:0]  eff_pos;
    logic [7:0]  new_chk;
    logic [39:0] flip, new_cw;

    always_comb begin
        new_chk = '0;
        for (int k = 0; k < 8; k++) begin
            new_chk[k] = ^(s.in_data & MASK[k]);
        end
    end

    // A full queue still accepts when the head leaves on the same edge.
    assign s.in_ready  = rst_n & ((count != 2'd2) | s.out_ready);
    assign s.out_valid = (count != 2'd0);
    assign s.out_data  = e0_data;
    assign s.out_chk   = e0_chk;
    assign inj_busy    = arm_q;

    assign push = s.in_valid & s.in_ready;
    assign pop  = s.out_valid & s.out_ready;

    // A fresh arm on the accepting edge takes precedence over a previously latched position.
    assign eff_arm = INJ_EN & (inj_arm | arm_q);
    assign eff_pos = inj_arm ? inj_pos : pos_q;

    always_comb begin
        flip = '0;
        if (eff_arm && (eff_pos < 6'd40)) begin
            flip = 40'd1 << eff_pos;
        end
        new_cw = {new_chk, s.in_data} ^ flip;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= 2'd0;
            e0_data  <= '0;
            e0_chk   <= '0;
            e1_data  <= '0;
            e1_chk   <= '0;
            arm_q    <= 1'b0;
            pos_q    <= '0;
            sent_cnt <= '0;
        end else begin
            if (pop) begin
                sent_cnt <= sent_cnt + 1'b1;
            end

            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        {e0_chk, e0_data} <= new_cw;
                    end else begin
                        {e1_chk, e1_data} <= new_cw;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    // With one entry the head keeps its value so the outputs hold the last popped word.
                    if (count == 2'd2) begin
                        e0_data <= e1_data;
                        e0_chk  <= e1_chk;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        {e0_chk, e0_data} <= new_cw;
                    end else begin
                        e0_data <= e1_data;
                        e0_chk  <= e1_chk;
                        {e1_chk, e1_data} <= new_cw;
                    end
                end
                default: ;
            endcase

            if (push && eff_arm) begin
                arm_q <= 1'b0;
            end else if (inj_arm && INJ_EN) begin
                arm_q <= 1'b1;
                pos_q <= inj_pos;
            end
        end
    end

endmodule

// File: tb/tb_sec32_check_encoder.sv
// tb/tb_sec32_check_encoder.sv - self-checking bench for sec32_check_encoder
`timescale 1ns/1ps
module tb_sec32_check_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       inj_arm;
    logic [5:0] inj_pos;
    logic       inj_busy;
    logic [3:0] sent_cnt;

    sec32_check_encoder_if s ();

    sec32_check_encoder #(.CNT_W(4), .INJ_EN(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s        (s),
        .inj_arm  (inj_arm),
        .inj_pos  (inj_pos),
        .inj_busy (inj_busy),
        .sent_cnt (sent_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] masks [8];
    logic [3:0]  exp_sent;
    logic [31:0] last_d;
    logic [7:0]  last_c;
    logic [39:0] sb [$];

    typedef struct {
        logic [31:0] data;
        logic [7:0]  chk;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Syndrome column of data bit i: which check equations the bit participates in.
    function automatic logic [7:0] col(input int i);
        logic [7:0] c;
        for (int k = 0; k < 8; k++) c[k] = masks[k][i];
        return c;
    endfunction

    function automatic logic [7:0] ref_chk(input logic [31:0] d);
        logic [7:0] c = '0;
        for (int i = 0; i < 32; i++) if (d[i]) c ^= col(i);
        return c;
    endfunction

    function automatic logic [31:0] checker_model(input logic [31:0] d, input logic [7:0] c);
        logic [7:0]  syn = ref_chk(d) ^ c;
        logic [31:0] r = d;
        if (syn != 8'h00)
            for (int i = 0; i < 32; i++) if (col(i) == syn) r[i] = ~r[i];
        return r;
    endfunction

    task automatic push_word(input logic [31:0] d);
        int n = 0;
        s.in_valid = 1'b1;
        s.in_data  = d;
        #1;
        while (!s.in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!s.in_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout actual=in_ready_low required=in_ready_high");
        end
        @(posedge clk); #1;
        s.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_word(input string nm, input logic [31:0] d, input logic [7:0] c);
        chk({nm, "_valid"}, s.out_valid, 1);
        chk({nm, "_data"}, s.out_data, d);
        chk({nm, "_chk"}, s.out_chk, c);
        s.out_ready = 1'b1;
        @(posedge clk); #1;
        s.out_ready = 1'b0;
        exp_sent++;
        last_d = d;
        last_c = c;
        @(negedge clk);
        chk({nm, "_sent"}, sent_cnt, exp_sent);
    endtask

    task automatic arm(input logic [5:0] p);
        inj_arm = 1'b1;
        inj_pos = p;
        @(posedge clk); #1;
        inj_arm = 1'b0;
        @(negedge clk);
        chk("inj_busy_set", inj_busy, 1);
    endtask

    // One random cycle against the queue scoreboard; starts and ends at a falling edge.
    task automatic rand_cycle(input bit allow_in, output bit accepted);
        logic [39:0] head;
        bit exp_ready, push, pop;
        s.in_valid  = allow_in && ($urandom_range(3) != 0);
        s.in_data   = $urandom;
        s.out_ready = ($urandom_range(4) < 3);
        #1;
        chk("rnd_sent", sent_cnt, exp_sent);
        chk("rnd_valid", s.out_valid, sb.size() > 0);
        exp_ready = (sb.size() < 2) || s.out_ready;
        chk("rnd_ready", s.in_ready, exp_ready);
        head = (sb.size() > 0) ? sb[0] : {last_c, last_d};
        chk("rnd_data", s.out_data, head[31:0]);
        chk("rnd_chk", s.out_chk, head[39:32]);
        push = s.in_valid && exp_ready;
        pop  = s.out_ready && (sb.size() > 0);
        if (pop) begin
            head = sb.pop_front();
            last_d = head[31:0];
            last_c = head[39:32];
            exp_sent++;
        end
        if (push) sb.push_back({ref_chk(s.in_data), s.in_data});
        accepted = push;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w1, w2, w3;
        int acc, cyc;
        bit a;

        masks[0] = 32'h00FF1111; masks[1] = 32'hFF002222;
        masks[2] = 32'h0F0F4444; masks[3] = 32'hF0F08888;
        masks[4] = 32'h111100FF; masks[5] = 32'h2222FF00;
        masks[6] = 32'h44440F0F; masks[7] = 32'h8888F0F0;
        vecs[0] = '{32'h00000000, 8'h00};
        vecs[1] = '{32'hFFFFFFFF, 8'h00};
        vecs[2] = '{32'h00000001, 8'h51};
        vecs[3] = '{32'h80000000, 8'h8A};
        vecs[4] = '{32'h00010000, 8'h15};

        rst_n = 1'b0; inj_arm = 1'b0; inj_pos = '0;
        s.in_valid = 1'b0; s.in_data = '0; s.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", s.in_ready, 0);
        chk("rst_out_valid", s.out_valid, 0);
        chk("rst_out_data", s.out_data, 0);
        chk("rst_out_chk", s.out_chk, 0);
        chk("rst_inj_busy", inj_busy, 0);
        chk("rst_sent", sent_cnt, 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", s.in_ready, 1);
        exp_sent = '0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            push_word(vecs[i].data);
            chk("vec_checker", checker_model(s.out_data, s.out_chk), vecs[i].data);
            pop_word("vec", vecs[i].data, vecs[i].chk);
            chk("vec_hold_valid", s.out_valid, 0);
            chk("vec_hold_data", s.out_data, vecs[i].data);
        end

        w1 = 32'h12345678; w2 = 32'hCAFEF00D; w3 = 32'h0BADBEEF;
        push_word(w1);
        push_word(w2);
        s.in_valid = 1'b1; s.in_data = w3;
        #1;
        chk("full_in_ready", s.in_ready, 0);
        s.out_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", s.in_ready, 1);
        chk("full_head", s.out_data, w1);
        @(posedge clk); #1;
        s.in_valid = 1'b0;
        exp_sent++;
        @(negedge clk);
        chk("full_sent", sent_cnt, exp_sent);
        pop_word("full2", w2, ref_chk(w2));
        pop_word("full3", w3, ref_chk(w3));
        chk("full_drained", s.out_valid, 0);

        arm(6'd5);
        push_word(32'h0);
        chk("inj5_busy_clr", inj_busy, 0);
        chk("inj5_checker", checker_model(s.out_data, s.out_chk), 32'h0);
        pop_word("inj5", 32'h20, 8'h00);
        arm(6'd39);
        push_word(32'h0);
        chk("inj39_checker", checker_model(s.out_data, s.out_chk), 32'h0);
        pop_word("inj39", 32'h0, 8'h80);
        arm(6'd45);
        push_word(32'h0);
        chk("inj45_busy_clr", inj_busy, 0);
        pop_word("inj45", 32'h0, 8'h00);
        inj_arm = 1'b1; inj_pos = 6'd0;
        push_word(32'h1);
        inj_arm = 1'b0;
        chk("inj_same_busy", inj_busy, 0);
        chk("inj_same_checker", checker_model(s.out_data, s.out_chk), 32'h1);
        pop_word("inj_same", 32'h0, 8'h51);

        push_word(32'hA);
        push_word(32'hB);
        arm(6'd3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", s.out_valid, 0);
        chk("mid_rst_busy", inj_busy, 0);
        chk("mid_rst_sent", sent_cnt, 0);
        chk("mid_rst_data", s.out_data, 0);
        exp_sent = '0;
        push_word(32'h1);
        pop_word("post_rst", 32'h1, 8'h51);

        acc = 0; cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            rand_cycle(1'b1, a);
            if (a) acc++;
            cyc++;
        end
        chk("rnd_accept_count", acc, 10000);
        cyc = 0;
        while (sb.size() > 0 && cyc < 200) begin
            rand_cycle(1'b0, a);
            cyc++;
        end
        chk("rnd_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
